// File: rtl/key_req_arbiter.sv
// Round-robin arbiter sharing one downstream req/key/ack port among N_REQ requesters,
// with a watchdog that aborts grants the responder never acknowledges.
module key_req_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned KEY_W   = 4,
    parameter int unsigned TIMEOUT = 16,
    localparam int unsigned IdW    = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int unsigned WdW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       s_req,
    input  logic [N_REQ*KEY_W-1:0] s_key,
    output logic [N_REQ-1:0]       s_ack,
    output logic                   m_req,
    output logic [KEY_W-1:0]       m_key,
    input  logic                   m_ack,
    output logic [IdW-1:0]         grant_id,
    output logic                   busy,
    output logic                   timeout_err,
    output logic [15:0]            done_count
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e           state_q, state_d;
    logic [IdW-1:0]   ptr_q, ptr_d;
    logic [WdW-1:0]   wd_q, wd_d;
    logic [IdW-1:0]   grant_id_q, grant_id_d;
    logic [KEY_W-1:0] m_key_q, m_key_d;
    logic             timeout_err_q, timeout_err_d;
    logic [15:0]      done_count_q, done_count_d;

    logic             win_valid;
    logic [IdW-1:0]   win_idx;

    // First requester at or after ptr+1, wrapping modulo N_REQ.
    always_comb begin
        int unsigned    idx;
        logic [IdW-1:0] idx_w;
        win_valid = 1'b0;
        win_idx   = '0;
        idx       = 0;
        idx_w     = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            idx_w = IdW'(idx);
            if (!win_valid && s_req[idx_w]) begin
                win_valid = 1'b1;
                win_idx   = idx_w;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        wd_d          = wd_q;
        grant_id_d    = grant_id_q;
        m_key_d       = m_key_q;
        timeout_err_d = 1'b0;
        done_count_d  = done_count_q;
        unique case (state_q)
            StIdle: begin
                if (win_valid) begin
                    grant_id_d = win_idx;
                    m_key_d    = s_key[win_idx*KEY_W +: KEY_W];
                    wd_d       = '0;
                    state_d    = StBusy;
                end
            end
            StBusy: begin
                if (m_ack) begin
                    ptr_d        = grant_id_q;
                    done_count_d = done_count_q + 16'd1;
                    state_d      = StIdle;
                end else if (wd_q == WdW'(TIMEOUT - 1)) begin
                    ptr_d         = grant_id_q;
                    timeout_err_d = 1'b1;
                    state_d       = StIdle;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            ptr_q         <= IdW'(N_REQ - 1);
            wd_q          <= '0;
            grant_id_q    <= '0;
            m_key_q       <= '0;
            timeout_err_q <= 1'b0;
            done_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            wd_q          <= wd_d;
            grant_id_q    <= grant_id_d;
            m_key_q       <= m_key_d;
            timeout_err_q <= timeout_err_d;
            done_count_q  <= done_count_d;
        end
    end

    // Acknowledge is steered combinationally so the requester sees it with no added latency.
    always_comb begin
        s_ack = '0;
        if (state_q == StBusy) begin
            s_ack[grant_id_q] = m_ack;
        end
    end

    assign m_req       = (state_q == StBusy);
    assign busy        = (state_q == StBusy);
    assign m_key       = m_key_q;
    assign grant_id    = grant_id_q;
    assign timeout_err = timeout_err_q;
    assign done_count  = done_count_q;

endmodule

// File: tb/tb_key_req_arbiter.sv
// Directed bench for key_req_arbiter: a transaction-level model checked every cycle,
// plus hand-computed expectations for reset, round-robin order, timeout and wrap.
module tb_key_req_arbiter;

    localparam int N  = 4;
    localparam int KW = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  s_req = '0;
    logic [N*KW-1:0] s_key = '0;
    logic [N-1:0]  s_ack;
    logic          m_req;
    logic [KW-1:0] m_key;
    logic          m_ack = 1'b0;
    logic [1:0]    grant_id;
    logic          busy;
    logic          timeout_err;
    logic [15:0]   done_count;

    int n_checks = 0;
    int n_err    = 0;

    key_req_arbiter #(.N_REQ(N), .KEY_W(KW), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_req      (s_req),
        .s_key      (s_key),
        .s_ack      (s_ack),
        .m_req      (m_req),
        .m_key      (m_key),
        .m_ack      (m_ack),
        .grant_id   (grant_id),
        .busy       (busy),
        .timeout_err(timeout_err),
        .done_count (done_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a grant is either outstanding (with its age in cycles) or not.
    bit          mb;
    int          mg;
    int          mptr;
    int          mage;
    logic [KW-1:0] mk;
    bit          mterr;
    logic [15:0] mdone;

    function automatic void model_reset();
        mb    = 1'b0;
        mg    = 0;
        mptr  = N - 1;
        mage  = 0;
        mk    = '0;
        mterr = 1'b0;
        mdone = '0;
    endfunction

    function automatic void model_step();
        logic [N-1:0] req_bits;
        int           w;
        mterr = 1'b0;
        if (!mb) begin
            req_bits = s_req;
            for (int d = 1; d <= N; d++) begin
                w = (mptr + d) % N;
                if (((req_bits >> w) & 4'd1) != 4'd0) begin
                    mg   = w;
                    mk   = KW'(s_key >> (w * KW));
                    mb   = 1'b1;
                    mage = 1;
                    break;
                end
            end
        end else if (m_ack) begin
            mptr  = mg;
            mdone = mdone + 16'd1;
            mb    = 1'b0;
        end else if (mage == TO) begin
            mptr  = mg;
            mterr = 1'b1;
            mb    = 1'b0;
        end else begin
            mage++;
        end
    endfunction

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) model_reset();
            chk("m_req", m_req, mb);
            chk("busy", busy, mb);
            chk("grant_id", grant_id, mg);
            chk("m_key", m_key, mk);
            chk("s_ack", s_ack, (mb && m_ack) ? (1 << mg) : 0);
            chk("timeout_err", timeout_err, mterr);
            chk("done_count", done_count, mdone);
            @(posedge clk);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_mreq(input string nm);
        int n = 0;
        while (m_req !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk(nm, m_req, 1);
    endtask

    initial begin
        int keys[4] = '{3, 5, 7, 9};
        int hi;

        s_key = {4'd9, 4'd7, 4'd5, 4'd3};
        s_req = 4'hF;
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_m_req", m_req, 0);
        chk("rst_s_ack", s_ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done_count, 0);
        rst_n = 1'b1;
        tick();
        chk("first_m_req", m_req, 1);
        chk("first_grant", grant_id, 0);
        chk("first_key", m_key, 3);

        for (int i = 0; i < 5; i++) begin
            wait_mreq("rr_wait");
            chk("rr_grant", grant_id, i % 4);
            if (i == 0) s_key[3:0] = 4'hA;
            tick();
            m_ack = 1'b1;
            #1;
            chk("rr_s_ack", s_ack, 1 << (i % 4));
            chk("rr_key", m_key, keys[i % 4]);
            tick();
            m_ack = 1'b0;
            if (i == 0) s_key[3:0] = 4'd3;
            if (i == 4) s_req = '0;
        end
        chk("rr_done", done_count, 5);

        s_req = 4'b0010;
        wait_mreq("to_wait");
        chk("to_grant", grant_id, 1);
        hi = 0;
        while (m_req === 1'b1 && hi < 40) begin
            hi++;
            tick();
        end
        chk("to_mreq_cycles", hi, 16);
        chk("to_err_pulse", timeout_err, 1);
        chk("to_done", done_count, 5);
        tick();
        chk("to_err_clear", timeout_err, 0);
        chk("to_regrant", m_req, 1);
        chk("to_regrant_id", grant_id, 1);
        s_req = '0;
        repeat (15) tick();
        chk("bd_still_busy", m_req, 1);
        m_ack = 1'b1;
        #1;
        chk("bd_s_ack", s_ack, 4'b0010);
        tick();
        m_ack = 1'b0;
        chk("bd_idle", m_req, 0);
        chk("bd_no_err", timeout_err, 0);
        chk("bd_done", done_count, 6);

        force dut.done_count_q = 16'hFFFF;
        mdone = 16'hFFFF;
        tick();
        release dut.done_count_q;
        chk("wrap_preload", done_count, 16'hFFFF);
        s_req = 4'b0001;
        wait_mreq("wrap_wait");
        s_req = '0;
        m_ack = 1'b1;
        tick();
        m_ack = 1'b0;
        chk("wrap_done", done_count, 0);

        s_req = 4'b0100;
        wait_mreq("ar_wait");
        chk("ar_grant", grant_id, 2);
        m_ack = 1'b1;
        #1;
        chk("ar_s_ack", s_ack, 4'b0100);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_m_req", m_req, 0);
        chk("ar_s_ack0", s_ack, 0);
        chk("ar_busy", busy, 0);
        m_ack = 1'b0;
        s_req = '0;
        tick();
        tick();
        chk("ar_done", done_count, 0);
        chk("ar_grant0", grant_id, 0);
        rst_n = 1'b1;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

endmodule
